mol7_serial_divisibility: RTL and testbench
===========================================

Name: mol7_serial_divisibility

Overview:
- Bit-serial divisibility detector.
- Consumes one bit per clock, MSB first, forming an unbounded binary number.
- Flags every cycle on which the number received so far is divisible by MOD (default 7).
- Sits on a serial data path as a streaming checker; no framing, no handshake.

Parameters:
- MOD, default 7: divisor; integer, 2 to 255; 7 is the only value required to be verified.
- RW, default $clog2(MOD): remainder state width; derived, do not override.

Ports:
- clk  input  1  clock, rising-edge active
- rst_n  input  1  synchronous active-low reset
- data_in  input  1  next serial bit, MSB first, sampled on every rising clk edge while rst_n=1
- vld  output  1  registered; 1 when the accumulated value, including the bit sampled at the most recent edge, is ≡ 0 mod MOD

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- State: remainder register rem[RW-1:0], values 0..MOD-1.
  - For MOD=7 this is a 7-state FSM S0..S6, where Sk means value mod 7 = k.
- Each rising edge with rst_n=1:
  - rem <= (2*rem + data_in) mod MOD;
  - vld <= ((2*rem + data_in) mod MOD == 0).
- Next-state arithmetic:
  - 2*rem+data_in needs at most RW+1 bits and is < 2*MOD.
  - Reduce with a single conditional subtract of MOD; no divider.
- MOD=7 transition table, current state -> next for bit 0 / bit 1:
  - S0 -> S0/S1
  - S1 -> S2/S3
  - S2 -> S4/S5
  - S3 -> S6/S0
  - S4 -> S1/S2
  - S5 -> S3/S4
  - S6 -> S5/S6
- Latency: vld reflects the bit sampled at the same edge. It is valid from that edge until the next edge; checkers sample shortly after posedge.
- Reset, rising edge with rst_n=0:
  - rem <= 0, vld <= 0.
  - data_in is ignored on that edge.
- Empty stream: vld stays 0 through reset, even though the empty value 0 is divisible.
- First bit after reset: 0 -> vld=1; 1 -> vld=0.
- Leading zeros: do not change rem; vld stays 1 while rem=0.
- Stream length is unbounded. The DUT tracks the exact remainder of the full bit history, with no 32-bit truncation. Reference models must use the true remainder, not a fixed-width accumulator.
- Reset mid-stream: history is discarded; the next bit starts a new number.
- Unreachable rem encodings (MOD..2^RW-1): next edge forces rem <= 0, vld <= 0.
- No X propagation: all registers are reset.

Optional Feature:
- Macro MOL7_REM_OUT_EN.
- Defined:
  - Adds output port rem_out [RW-1:0], the registered remainder.
  - Same timing as vld; 0 in reset.
  - vld == (rem_out == 0) whenever not in reset or the first post-reset state.
- Undefined:
  - Port is absent.
  - Remainder stays internal; functionality otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with data_in toggling -> vld=0, rem=0 throughout.
- Sequence 1,1,1,0,1,0,0,1 after reset (values 1,3,7,14,29,58,116,233) -> vld = 0,0,1,1,0,0,0,0.
- Seven-multiple 10101 (21) then 0 (42) then 1 (85) -> vld after each bit = 0,0,0,0,1,1,0.
- All-ones stream of 9 bits (1,3,7,15,31,63,127,255,511) -> vld = 0,0,1,0,0,1,0,0,1 (every third bit).
- Mid-stream reset: send 1,1,0 (rem 6), assert rst_n=0 for one edge, then send 0 -> vld=1, rem=0.
- Random 1000-bit stream vs an unbounded remainder model (r=(2r+b)%7) -> zero mismatches, including beyond 32 bits.

Source files
------------

// File: rtl/mol7_serial_divisibility_if.sv
// Serial data path bundle for the divisibility checker: one input bit per clock plus the flag.
// Optional rem_out signal is present when MOL7_REM_OUT_EN is defined.
interface mol7_serial_divisibility_if #(
    parameter int unsigned MOD = 7,
    parameter int unsigned RW  = $clog2(MOD)
);
    logic          data_in;
    logic          vld;
`ifdef MOL7_REM_OUT_EN
    logic [RW-1:0] rem_out;

    modport master (output data_in, input vld, input rem_out);
    modport slave  (input data_in, output vld, output rem_out);
`else
    modport master (output data_in, input vld);
    modport slave  (input data_in, output vld);
`endif
endinterface

// File: rtl/mol7_serial_divisibility.sv
// Bit-serial MSB-first divisibility detector: vld flags every cycle the stream so far is 0 mod MOD.
// Optional macro MOL7_REM_OUT_EN exposes the registered remainder on the interface as rem_out.
module mol7_serial_divisibility #(
    parameter int unsigned MOD = 7,
    parameter int unsigned RW  = $clog2(MOD)
) (
    input logic                       clk,
    input logic                       rst_n,
    mol7_serial_divisibility_if.slave bus
);
    localparam logic [RW:0] MOD_W = (RW+1)'(MOD);

    logic [RW-1:0] rem_q, rem_d;
    logic          vld_q, vld_d;
    logic [RW:0]   sum;

    // 2*rem + bit is always < 2*MOD, so one conditional subtract fully reduces it;
    // unreachable encodings (rem >= MOD) collapse back to 0 with vld low.
    always_comb begin
        sum   = {rem_q, bus.data_in};
        rem_d = '0;
        vld_d = 1'b0;
        if ({1'b0, rem_q} < MOD_W) begin
            rem_d = (sum >= MOD_W) ? RW'(sum - MOD_W) : sum[RW-1:0];
            vld_d = (rem_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            vld_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            vld_q <= vld_d;
        end
    end

    assign bus.vld = vld_q;
`ifdef MOL7_REM_OUT_EN
    assign bus.rem_out = rem_q;
`endif
endmodule

// File: tb/tb_mol7_serial_divisibility.sv
// Scoreboard bench for mol7_serial_divisibility (MOD=7): stimulus pushes expectations, monitor pops and checks.
module tb_mol7_serial_divisibility;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mol7_serial_divisibility_if #(.MOD(7)) bus ();

    mol7_serial_divisibility #(.MOD(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  vld;
        int    rem;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   r      = 0;   // unbounded-stream remainder model: only (value mod 7) is ever needed
    logic stim_done = 1'b0;

    // One edge of stimulus: inputs change on negedge, the following posedge samples them.
    task automatic drive(input logic b, input logic rn, input logic exp_v, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n       = rn;
        bus.data_in = b;
        if (!rn) r = 0;
        else     r = (2 * r + int'(b)) % 7;
        e.vld  = exp_v;
        e.rem  = r;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic send_seq(input logic [15:0] bits, input logic [15:0] vlds, input int n, input string nm);
        drive(1'b0, 1'b0, 1'b0, {nm, "_rst"});
        for (int i = n - 1; i >= 0; i--)
            drive(bits[i], 1'b1, vlds[i], nm);
    endtask

    // Monitor: the DUT presents a result every edge; compare whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.vld !== e.vld)
                    $display("FAIL %s vld: got %b expected %b (t=%0t)", e.name, bus.vld, e.vld, $time);
                else
                    passed++;
`ifdef MOL7_REM_OUT_EN
                checks++;
                if (bus.rem_out !== 3'(e.rem))
                    $display("FAIL %s rem_out: got %0d expected %0d (t=%0t)", e.name, bus.rem_out, e.rem, $time);
                else
                    passed++;
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic b;
        int   nr;
        bus.data_in = 1'b0;

        // Reset held 3 edges with data toggling
        drive(1'b1, 1'b0, 1'b0, "reset0");
        drive(1'b0, 1'b0, 1'b0, "reset1");
        drive(1'b1, 1'b0, 1'b0, "reset2");

        // 1,3,7,14,29,58,116,233
        send_seq(16'b1110_1001, 16'b0011_0000, 8, "seq233");
        // 1,2,5,10,21,42,85
        send_seq(16'b101_0101, 16'b000_0110, 7, "seq85");
        // all ones: 1,3,7,...,511
        send_seq(16'b1_1111_1111, 16'b0_0100_1001, 9, "ones9");
        // leading zeros then 1,3,7
        send_seq(16'b00_0111, 16'b11_1001, 6, "lead0");

        // Mid-stream reset: 1,1,0 (rem 6), reset one edge, then 0
        drive(1'b0, 1'b0, 1'b0, "mid_rst0");
        drive(1'b1, 1'b1, 1'b0, "mid_a");
        drive(1'b1, 1'b1, 1'b0, "mid_b");
        drive(1'b0, 1'b1, 1'b0, "mid_c");
        drive(1'b1, 1'b0, 1'b0, "mid_rst");
        drive(1'b0, 1'b1, 1'b1, "mid_after");

        // Long random stream, with rare resets, against the remainder model
        drive(1'b0, 1'b0, 1'b0, "rand_rst0");
        for (int i = 0; i < 1000; i++) begin
            b = 1'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                drive(b, 1'b0, 1'b0, "rand_rst");
            end else begin
                nr = (2 * r + int'(b)) % 7;
                drive(b, 1'b1, (nr == 0), "rand");
            end
        end

        repeat (3) @(negedge clk);
        stim_done = 1'b1;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
